// File: rtl/icache_dm_pkg.sv
// Shared types and width helpers for the direct-mapped instruction cache.
package icache_dm_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int WORD_W = 32;

    // Word-aligned byte addresses leave 30 bits to split between tag, index and offset.
    function automatic int offWidth(input int lineWords);
        return $clog2(lineWords);
    endfunction

    function automatic int idxWidth(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tagWidth(input int lines, input int lineWords);
        return WORD_W - 2 - $clog2(lines) - $clog2(lineWords);
    endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-side and refill-side signals of the instruction cache, bundled for port lists.
interface icache_dm_if;

    logic [31:0] pc;
    logic [31:0] instr;
    logic        miss_stall;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  pc, flush, mem_ack, mem_rdata,
        output instr, miss_stall, mem_req, mem_addr
    );

    modport master (
        output pc, flush, mem_ack, mem_rdata,
        input  instr, miss_stall, mem_req, mem_addr
    );

endinterface

// File: rtl/icache_dm_array.sv
// Tag, valid and data storage: asynchronous read by index, synchronous word and line writes.
module icache_dm_array
    import icache_dm_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4,
    localparam int OFF_W     = offWidth(LINE_WORDS),
    localparam int IDX_W     = idxWidth(LINES),
    localparam int TAG_W     = tagWidth(LINES, LINE_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rdIdx_i,
    input  logic [OFF_W-1:0]  rdOff_i,
    output logic              rdValid_o,
    output logic [TAG_W-1:0]  rdTag_o,
    output logic [WORD_W-1:0] rdData_o,
    input  logic              wrEn_i,
    input  logic [IDX_W-1:0]  wrIdx_i,
    input  logic [OFF_W-1:0]  wrOff_i,
    input  logic [WORD_W-1:0] wrData_i,
    input  logic              setValid_i,
    input  logic [TAG_W-1:0]  setTag_i,
    input  logic              clearAll_i
);

    logic [WORD_W-1:0] data_q [LINES][LINE_WORDS];
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINES-1:0]  valid_q;

    // Tag and data contents are never reset; only the valid bits gate hits.
    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            data_q[wrIdx_i][wrOff_i] <= wrData_i;
        end
        if (setValid_i) begin
            tag_q[wrIdx_i] <= setTag_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clearAll_i) begin
            valid_q <= '0;
        end else if (setValid_i) begin
            valid_q[wrIdx_i] <= 1'b1;
        end
    end

    assign rdValid_o = valid_q[rdIdx_i];
    assign rdTag_o   = tag_q[rdIdx_i];
    assign rdData_o  = data_q[rdIdx_i][rdOff_i];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: zero-latency hits, whole-line refill on a miss.
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    icache_dm_if.slave  bus
);

    localparam int OFF_W = offWidth(LINE_WORDS);
    localparam int IDX_W = idxWidth(LINES);
    localparam int TAG_W = tagWidth(LINES, LINE_WORDS);

    state_t            state_q, state_d;
    logic [OFF_W-1:0]  wordCnt_q, wordCnt_d;
    logic [TAG_W-1:0]  missTag_q, missTag_d;
    logic [IDX_W-1:0]  missIdx_q, missIdx_d;
    logic              flushPend_q, flushPend_d;

    logic [OFF_W-1:0]  pcOff;
    logic [IDX_W-1:0]  pcIdx;
    logic [TAG_W-1:0]  pcTag;
    logic              rdValid;
    logic [TAG_W-1:0]  rdTag;
    logic [WORD_W-1:0] rdData;
    logic              hit;
    logic              lastWord;
    logic              arrWrEn;
    logic              arrSetValid;
    logic              arrClear;
    logic              unusedPcBits;

    assign pcOff        = bus.pc[OFF_W+1:2];
    assign pcIdx        = bus.pc[IDX_W+OFF_W+1:OFF_W+2];
    assign pcTag        = bus.pc[WORD_W-1:IDX_W+OFF_W+2];
    assign unusedPcBits = ^bus.pc[1:0];

    icache_dm_array #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_array (
        .clk        (clk),
        .reset      (reset),
        .rdIdx_i    (pcIdx),
        .rdOff_i    (pcOff),
        .rdValid_o  (rdValid),
        .rdTag_o    (rdTag),
        .rdData_o   (rdData),
        .wrEn_i     (arrWrEn),
        .wrIdx_i    (missIdx_q),
        .wrOff_i    (wordCnt_q),
        .wrData_i   (bus.mem_rdata),
        .setValid_i (arrSetValid),
        .setTag_i   (missTag_q),
        .clearAll_i (arrClear)
    );

    assign hit      = rdValid && (rdTag == pcTag);
    assign lastWord = (wordCnt_q == {OFF_W{1'b1}});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wordCnt_q   <= '0;
            missTag_q   <= '0;
            missIdx_q   <= '0;
            flushPend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wordCnt_q   <= wordCnt_d;
            missTag_q   <= missTag_d;
            missIdx_q   <= missIdx_d;
            flushPend_q <= flushPend_d;
        end
    end

    // A flush seen mid-refill is remembered so the line is discarded once all acks are consumed.
    always_comb begin
        state_d     = state_q;
        wordCnt_d   = wordCnt_q;
        missTag_d   = missTag_q;
        missIdx_d   = missIdx_q;
        flushPend_d = flushPend_q;
        case (state_q)
            S_IDLE: begin
                if (!hit) begin
                    state_d     = S_FILL;
                    missTag_d   = pcTag;
                    missIdx_d   = pcIdx;
                    wordCnt_d   = '0;
                    flushPend_d = 1'b0;
                end
            end
            S_FILL: begin
                if (bus.flush) begin
                    flushPend_d = 1'b1;
                end
                if (bus.mem_ack) begin
                    wordCnt_d = wordCnt_q + OFF_W'(1);
                    if (lastWord) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                flushPend_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_addr   = '0;
        bus.miss_stall = 1'b1;
        bus.instr      = '0;
        arrWrEn        = 1'b0;
        arrSetValid    = 1'b0;
        arrClear       = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.miss_stall = !hit;
                bus.instr      = hit ? rdData : '0;
                arrClear       = bus.flush;
            end
            S_FILL: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {missTag_q, missIdx_q, wordCnt_q, 2'b00};
                arrWrEn      = bus.mem_ack;
            end
            S_DONE: begin
                arrSetValid = !(flushPend_q || bus.flush);
                arrClear    = flushPend_q || bus.flush;
            end
            default: begin
                bus.miss_stall = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: a hit table plus hand-written miss, slow-memory, flush and reset sequences.
module tb_icache_dm;

    localparam logic [31:0] KEY = 32'hA5A5A5A5;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] expInstr;
        logic        expStall;
        logic        expReq;
    } vec_t;

    logic clk;
    logic reset;
    int   ackDelay;
    int   waitCnt;
    int   ackCount;
    logic holdPending;
    logic [31:0] heldAddr;
    int   checkCount;
    int   passCount;
    vec_t hitTable [8];

    icache_dm_if bus();

    icache_dm #(
        .LINES      (16),
        .LINE_WORDS (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: answers with address^KEY after ackDelay waiting cycles per word.
    assign bus.mem_ack   = bus.mem_req && (waitCnt >= ackDelay);
    assign bus.mem_rdata = bus.mem_addr ^ KEY;

    always @(posedge clk) begin
        if (bus.mem_req && !bus.mem_ack) begin
            waitCnt <= waitCnt + 1;
        end else begin
            waitCnt <= 0;
        end
        if (bus.mem_req && bus.mem_ack) begin
            ackCount <= ackCount + 1;
        end
        holdPending <= bus.mem_req && !bus.mem_ack && !reset;
        heldAddr    <= bus.mem_addr;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s got=%h want=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic flush, input logic rst);
        @(posedge clk);
        #1;
        bus.pc    = pc;
        bus.flush = flush;
        reset     = rst;
    endtask

    // Called at the negedge of the miss cycle; follows the refill until the hit appears.
    task automatic waitFill(input logic [31:0] missPc, input int expPenalty, input string name);
        logic [31:0] base;
        int k;
        int cycles;
        bit done;
        base   = {missPc[31:4], 4'h0};
        k      = 0;
        cycles = 0;
        done   = 0;
        checkOutput({name, " missCycleStall"}, {31'd0, bus.miss_stall}, 32'd1);
        checkOutput({name, " missCycleInstr"}, bus.instr, 32'd0);
        checkOutput({name, " missCycleReq"}, {31'd0, bus.mem_req}, 32'd0);
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (!bus.miss_stall) begin
                done = 1;
            end else begin
                cycles++;
                checkOutput({name, " stallInstr"}, bus.instr, 32'd0);
                if (holdPending) begin
                    checkOutput({name, " addrHeld"}, bus.mem_addr, heldAddr);
                end
                if (bus.mem_req && bus.mem_ack) begin
                    checkOutput({name, " refillAddr"}, bus.mem_addr, base + 32'(k * 4));
                    k++;
                end
            end
        end
        checkOutput({name, " finished"}, {31'd0, done}, 32'd1);
        checkOutput({name, " penalty"}, 32'(cycles), 32'(expPenalty));
        checkOutput({name, " wordsFetched"}, 32'(k), 32'd4);
        checkOutput({name, " hitInstr"}, bus.instr, {missPc[31:2], 2'b00} ^ KEY);
    endtask

    task automatic doMiss(input logic [31:0] missPc, input int expPenalty, input string name);
        applyStimulus(missPc, 1'b0, 1'b0);
        @(negedge clk);
        waitFill(missPc, expPenalty, name);
    endtask

    initial begin
        int startAcks;
        bit reached;
        checkCount = 0;
        passCount  = 0;
        ackDelay   = 0;
        bus.pc     = 32'h40;
        bus.flush  = 1'b0;
        reset      = 1'b1;

        hitTable[0] = '{32'h40, 32'h40 ^ KEY, 1'b0, 1'b0};
        hitTable[1] = '{32'h44, 32'h44 ^ KEY, 1'b0, 1'b0};
        hitTable[2] = '{32'h48, 32'h48 ^ KEY, 1'b0, 1'b0};
        hitTable[3] = '{32'h4C, 32'h4C ^ KEY, 1'b0, 1'b0};
        hitTable[4] = '{32'h8C, 32'h8C ^ KEY, 1'b0, 1'b0};
        hitTable[5] = '{32'h80, 32'h80 ^ KEY, 1'b0, 1'b0};
        hitTable[6] = '{32'h4A, 32'h48 ^ KEY, 1'b0, 1'b0};
        hitTable[7] = '{32'h84, 32'h84 ^ KEY, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset stall", {31'd0, bus.miss_stall}, 32'd1);
        checkOutput("reset instr", bus.instr, 32'd0);
        checkOutput("reset req", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("reset addr", bus.mem_addr, 32'd0);

        doMiss(32'h40, 5, "cold");
        doMiss(32'h88, 5, "second line");

        for (int i = 0; i < 8; i++) begin
            applyStimulus(hitTable[i].pc, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("hit%0d instr", i), bus.instr, hitTable[i].expInstr);
            checkOutput($sformatf("hit%0d stall", i), {31'd0, bus.miss_stall}, {31'd0, hitTable[i].expStall});
            checkOutput($sformatf("hit%0d req", i), {31'd0, bus.mem_req}, {31'd0, hitTable[i].expReq});
        end

        doMiss(32'h440, 5, "conflict");
        applyStimulus(32'h84, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("other line survives", bus.instr, 32'h84 ^ KEY);
        doMiss(32'h40, 5, "evicted refetch");

        ackDelay = 3;
        doMiss(32'hC0, 17, "slow");
        ackDelay = 0;

        // Flush while idle: the hit is still presented, the following cycle misses.
        applyStimulus(32'h40, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("idle flush same-cycle hit", {31'd0, bus.miss_stall}, 32'd0);
        doMiss(32'h40, 5, "after idle flush");

        // Flush on the second word of a refill.
        applyStimulus(32'hC0, 1'b0, 1'b0);
        startAcks = ackCount;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        reached = 0;
        for (int c = 0; c < 50 && !reached; c++) begin
            @(negedge clk);
            if (ackCount - startAcks >= 4) reached = 1;
        end
        checkOutput("fill flush acks", 32'(ackCount - startAcks), 32'd4);
        checkOutput("fill flush done stall", {31'd0, bus.miss_stall}, 32'd1);
        checkOutput("fill flush done req", {31'd0, bus.mem_req}, 32'd0);
        bus.pc = 32'h40;
        @(negedge clk);
        waitFill(32'h40, 5, "after fill flush");
        doMiss(32'h80, 5, "other line flushed");

        // Reset after two acks of a refill.
        applyStimulus(32'h100, 1'b0, 1'b0);
        startAcks = ackCount;
        reached = 0;
        for (int c = 0; c < 50 && !reached; c++) begin
            @(negedge clk);
            if (ackCount - startAcks >= 2) reached = 1;
        end
        checkOutput("reset mid-fill acks", 32'(ackCount - startAcks), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset mid-fill req", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("reset mid-fill addr", bus.mem_addr, 32'd0);
        checkOutput("reset mid-fill stall", {31'd0, bus.miss_stall}, 32'd1);
        reset  = 1'b0;
        bus.pc = 32'h40;
        #1;
        waitFill(32'h40, 5, "after reset");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
